// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared types, defaults and sizing helper for the PLL lock supervisor
//
// Contents:
//   sup_state_t   supervisor FSM state
//   DEF_*         default parameter values
//   timer_width() bit width for the single shared cycle timer

package pll_sup_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    PLL_RST   = 2'd3
  } sup_state_t;

  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_RELOCK_TIMEOUT = 1048576;
  localparam int DEF_PLLRST_CYCLES  = 16;
  localparam int DEF_CNT_W          = 8;

  // One timer serves the WAIT_LOCK, STABLE and PLL_RST phases. It never
  // needs to hold more than (largest cycle count - 1), so $clog2 of the
  // largest count is enough; a 1-bit floor keeps the vector legal.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
//
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low reset, both flops clear to 0
//   d      asynchronous input level
//   q      synchronized level, lags d by two clk edges

module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - qualifies PLL lock and releases the downstream reset
//
// Optional feature macro: PLLSUP_AUTORESET_EN
//   defined   : a lock timeout enters PLL_RST and pulses pll_rst
//   undefined : a lock timeout only sets timeout_err; pll_rst is tied 0
//
// Ports:
//   clk            PLL output clock, all logic runs on it
//   rstn           asynchronous active-low reset
//   locked_i       raw PLL lock flag, asynchronous to clk
//   rst_out_n      registered active-low reset for downstream logic (high only in RUN)
//   ready          high while in RUN
//   pll_rst        active-high PLL reset request
//   lock_loss_cnt  saturating count of RUN -> WAIT_LOCK transitions
//   timeout_err    sticky lock-timeout flag, cleared only by rstn

module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int RELOCK_TIMEOUT = DEF_RELOCK_TIMEOUT,
  parameter int PLLRST_CYCLES  = DEF_PLLRST_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             locked_i,
  output logic             rst_out_n,
  output logic             ready,
  output logic             pll_rst,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic             timeout_err
);

  localparam int TW = timer_width(STABLE_CYCLES, RELOCK_TIMEOUT, PLLRST_CYCLES);

  // Terminal timer values: the phase ends on the edge where the timer
  // already holds N-1, which gives exactly N edges spent in that phase.
  localparam logic [TW-1:0] T_STABLE_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] T_TIMEOUT_LAST = TW'(RELOCK_TIMEOUT - 1);
`ifdef PLLSUP_AUTORESET_EN
  localparam logic [TW-1:0] T_PLLRST_LAST  = TW'(PLLRST_CYCLES - 1);
`endif

  sup_state_t      state;
  logic [TW-1:0]   timer;
  logic            lk_s;
`ifdef PLLSUP_AUTORESET_EN
  logic            pll_rst_q;
`endif

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rstn),
    .d     (locked_i),
    .q     (lk_s)
  );

  // All outputs are written in the same branch as the state change that
  // implies them, so they move on exactly the transition edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= WAIT_LOCK;
      timer         <= '0;
      rst_out_n     <= 1'b0;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
      timeout_err   <= 1'b0;
`ifdef PLLSUP_AUTORESET_EN
      pll_rst_q     <= 1'b0;
`endif
    end else begin
      case (state)
        WAIT_LOCK: begin
          // Lock wins over a timeout landing on the same edge.
          if (lk_s) begin
            state <= STABLE;
            timer <= '0;
          end else if (timer == T_TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
`ifdef PLLSUP_AUTORESET_EN
            state     <= PLL_RST;
            timer     <= '0;
            pll_rst_q <= 1'b1;
`endif
            // Without auto-reset the timer simply sits at its last value.
          end else begin
            timer <= timer + 1'b1;
          end
        end

        STABLE: begin
          // A drop while qualifying is not a lock loss: counter untouched.
          if (!lk_s) begin
            state <= WAIT_LOCK;
            timer <= '0;
          end else if (timer == T_STABLE_LAST) begin
            state     <= RUN;
            timer     <= '0;
            rst_out_n <= 1'b1;
            ready     <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        RUN: begin
          if (!lk_s) begin
            state     <= WAIT_LOCK;
            timer     <= '0;
            rst_out_n <= 1'b0;
            ready     <= 1'b0;
            if (lock_loss_cnt != {CNT_W{1'b1}}) begin
              lock_loss_cnt <= lock_loss_cnt + 1'b1;
            end
          end
        end

`ifdef PLLSUP_AUTORESET_EN
        PLL_RST: begin
          // lk_s deliberately ignored: the PLL is being reset.
          if (timer == T_PLLRST_LAST) begin
            state     <= WAIT_LOCK;
            timer     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif

        default: begin
          state     <= WAIT_LOCK;
          timer     <= '0;
          rst_out_n <= 1'b0;
          ready     <= 1'b0;
`ifdef PLLSUP_AUTORESET_EN
          pll_rst_q <= 1'b0;
`endif
        end
      endcase
    end
  end

`ifdef PLLSUP_AUTORESET_EN
  assign pll_rst = pll_rst_q;
`else
  assign pll_rst = 1'b0;
`endif

endmodule
